// File: rtl/otbn_pq_ntt_seq_pkg.sv
// Shared PQ definitions: ALU opcodes and NTT sequencer FSM states.
package otbn_pq_ntt_seq_pkg;

  typedef enum logic [2:0] {
    AluOpPqAdd,
    AluOpPqSub,
    AluOpPqMontMul,
    AluOpPqButterflyCT,
    AluOpPqButterflyGS
  } alu_op_pq_e;

  typedef enum logic [1:0] {
    NttSeqIdle,
    NttSeqIssue,
    NttSeqDone
  } ntt_seq_state_e;

endpackage

// File: rtl/otbn_pq_ntt_addr_gen.sv
// Combinational next-butterfly computation: advances (j, base, len, k) one step
// and derives the index pair, twiddle and last flag of the resulting butterfly.
module otbn_pq_ntt_addr_gen #(
  parameter int unsigned LogN = 8
) (
  input  logic            inverse_i,
  input  logic [LogN:0]   j_i,
  input  logic [LogN:0]   base_i,
  input  logic [LogN:0]   len_i,
  input  logic [LogN:0]   k_i,
  output logic [LogN:0]   j_o,
  output logic [LogN:0]   base_o,
  output logic [LogN:0]   len_o,
  output logic [LogN:0]   k_o,
  output logic [LogN-1:0] idx0_o,
  output logic [LogN-1:0] idx1_o,
  output logic [LogN-1:0] twiddle_o,
  output logic            last_o
);

  localparam int unsigned CW = LogN + 1;
  localparam logic [CW-1:0] One   = CW'(1);
  localparam logic [CW-1:0] NVal  = One << LogN;
  localparam logic [CW-1:0] HalfN = NVal >> 1;

  logic final_stage;

  always_comb begin
    j_o    = j_i + One;
    base_o = base_i;
    len_o  = len_i;
    k_o    = k_i;
    if (j_i == len_i - One) begin
      j_o = '0;
      k_o = inverse_i ? (k_i - One) : (k_i + One);
      if ((base_i + (len_i << 1)) < NVal) begin
        base_o = base_i + (len_i << 1);
      end else begin
        base_o = '0;
        len_o  = inverse_i ? (len_i << 1) : (len_i >> 1);
      end
    end

    // Flag describes the butterfly the new counters point at, so it can be registered alongside it.
    final_stage = inverse_i ? (len_o == HalfN) : (len_o == One);
    last_o      = final_stage && (j_o == len_o - One) && ((base_o + (len_o << 1)) == NVal);

    idx0_o    = LogN'(base_o + j_o);
    idx1_o    = LogN'(base_o + j_o + len_o);
    twiddle_o = LogN'(k_o);
  end

endmodule

// File: rtl/otbn_pq_ntt_seq.sv
// NTT/INTT butterfly sequencer: issues every butterfly of a length-2^LogN
// transform as a valid/ready command with fully registered outputs.
module otbn_pq_ntt_seq
  import otbn_pq_ntt_seq_pkg::*;
#(
  parameter int unsigned LogN = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            inverse_i,
  input  logic            abort_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            bf_valid_o,
  input  logic            bf_ready_i,
  output logic [LogN-1:0] bf_idx0_o,
  output logic [LogN-1:0] bf_idx1_o,
  output logic [LogN-1:0] bf_twiddle_idx_o,
  output alu_op_pq_e      bf_op_o,
  output logic            bf_last_o
);

  localparam int unsigned CW = LogN + 1;
  localparam logic [CW-1:0] One   = CW'(1);
  localparam logic [CW-1:0] NVal  = One << LogN;
  localparam logic [CW-1:0] HalfN = NVal >> 1;

  ntt_seq_state_e  state_q, state_d;
  logic [CW-1:0]   j_q, j_d, base_q, base_d, len_q, len_d, k_q, k_d;
  logic [LogN-1:0] idx0_q, idx0_d, idx1_q, idx1_d, tw_q, tw_d;
  alu_op_pq_e      op_q, op_d;
  logic            last_q, last_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  logic [CW-1:0]   j_n, base_n, len_n, k_n;
  logic [LogN-1:0] idx0_n, idx1_n, tw_n;
  logic            last_n;

  otbn_pq_ntt_addr_gen #(.LogN(LogN)) u_addr_gen (
    .inverse_i (op_q == AluOpPqButterflyGS),
    .j_i       (j_q),
    .base_i    (base_q),
    .len_i     (len_q),
    .k_i       (k_q),
    .j_o       (j_n),
    .base_o    (base_n),
    .len_o     (len_n),
    .k_o       (k_n),
    .idx0_o    (idx0_n),
    .idx1_o    (idx1_n),
    .twiddle_o (tw_n),
    .last_o    (last_n)
  );

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    base_d  = base_q;
    len_d   = len_q;
    k_d     = k_q;
    idx0_d  = idx0_q;
    idx1_d  = idx1_q;
    tw_d    = tw_q;
    op_d    = op_q;
    last_d  = last_q;

    unique case (state_q)
      NttSeqIdle: begin
        if (start_i) begin
          state_d = NttSeqIssue;
          j_d     = '0;
          base_d  = '0;
          len_d   = inverse_i ? One : HalfN;
          k_d     = inverse_i ? (NVal - One) : One;
          op_d    = inverse_i ? AluOpPqButterflyGS : AluOpPqButterflyCT;
          idx0_d  = '0;
          idx1_d  = LogN'(len_d);
          tw_d    = LogN'(k_d);
          last_d  = 1'b0;
        end
      end
      NttSeqIssue: begin
        // Abort wins over a handshake in the same cycle.
        if (abort_i) begin
          state_d = NttSeqIdle;
        end else if (valid_q && bf_ready_i) begin
          j_d    = j_n;
          base_d = base_n;
          len_d  = len_n;
          k_d    = k_n;
          idx0_d = idx0_n;
          idx1_d = idx1_n;
          tw_d   = tw_n;
          last_d = last_n;
          if (last_q) state_d = NttSeqDone;
        end
      end
      NttSeqDone: state_d = NttSeqIdle;
      default:    state_d = NttSeqIdle;
    endcase

    valid_d = (state_d == NttSeqIssue);
    busy_d  = (state_d != NttSeqIdle);
    done_d  = (state_d == NttSeqDone) && (state_q != NttSeqDone);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= NttSeqIdle;
      j_q     <= '0;
      base_q  <= '0;
      len_q   <= '0;
      k_q     <= '0;
      idx0_q  <= '0;
      idx1_q  <= '0;
      tw_q    <= '0;
      op_q    <= AluOpPqButterflyCT;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      base_q  <= base_d;
      len_q   <= len_d;
      k_q     <= k_d;
      idx0_q  <= idx0_d;
      idx1_q  <= idx1_d;
      tw_q    <= tw_d;
      op_q    <= op_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign bf_valid_o       = valid_q;
  assign bf_idx0_o        = idx0_q;
  assign bf_idx1_o        = idx1_q;
  assign bf_twiddle_idx_o = tw_q;
  assign bf_op_o          = op_q;
  assign bf_last_o        = last_q;

endmodule

// File: doc/otbn_pq_ntt_seq.md
# otbn_pq_ntt_seq

NTT/INTT butterfly sequencer for the PQ wide datapath. On a start request it walks every stage, group and butterfly of a length-2^LogN transform. Each step is issued as a valid/ready command carrying the coefficient index pair, the twiddle index and the butterfly ALU opcode. It sits between the PQ instruction decoder / control SPRs and the PQ ALU, replacing software-driven M/J2/J/Idx loop bookkeeping for full-transform operations.

## Interface
- LogN, default 8: log2 of transform length N; legal range 2..10.
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  begin a transform; honoured only in IDLE.
- inverse_i  in  1  sampled with start_i; 0 = forward Cooley-Tukey, 1 = inverse Gentleman-Sande.
- abort_i  in  1  cancel the running transform.
- busy_o  out  1  high in ISSUE and DONE.
- done_o  out  1  one-cycle pulse on completion.
- bf_valid_o  out  1  butterfly command valid.
- bf_ready_i  in  1  ALU accepts the command.
- bf_idx0_o  out  LogN  lower coefficient index.
- bf_idx1_o  out  LogN  upper coefficient index (idx0 + len).
- bf_twiddle_idx_o  out  LogN  twiddle table index (1..N-1).
- bf_op_o  out  alu_op_pq_e  AluOpPqButterflyCT (forward) or AluOpPqButterflyGS (inverse).
- bf_last_o  out  1  marks the final butterfly of the transform.

## Operation
- State machine: IDLE, ISSUE, DONE.
  - IDLE: on start_i, latch inverse_i, initialise counters, go to ISSUE.
  - ISSUE: present the current butterfly; advance on bf_valid_o && bf_ready_i. Handshake of the butterfly with bf_last_o set goes to DONE.
  - DONE: done_o = 1 for one cycle, then go to IDLE.
- Counters: len (power of two), base (group start), j (offset in group, 0..len-1), k (twiddle index).
- Every butterfly: idx0 = base + j; idx1 = base + j + len; twiddle = k.
- Forward ordering:
  - len starts at N/2 and halves each stage, ending at 1.
  - k starts at 1 and increments at each group end.
- Inverse ordering:
  - len starts at 1 and doubles each stage, ending at N/2.
  - k starts at N-1 and decrements at each group end.
- Advance rules on handshake:
  - j < len-1: j++.
  - Else (group end): j = 0 and k steps.
    - If base + 2·len < N: base += 2·len.
    - Else (stage end): base = 0 and len steps.
- bf_last_o = final stage && group end && base + 2·len == N.
- Total butterflies per transform: (N/2)·LogN. k covers 1..N-1 exactly once per transform.
- start_i outside IDLE is ignored; inverse_i is only sampled with start_i.
- abort_i in ISSUE or DONE:
  - Next state IDLE, bf_valid_o drops, no done_o.
  - abort_i has priority over a simultaneous handshake.
- Counter arithmetic is LogN+1 bits internally so that base + 2·len == N is representable. Outputs are truncated to LogN bits, which never overflow.

## Timing
- Reset values:
  - state IDLE; busy_o, done_o, bf_valid_o and bf_last_o = 0.
  - idx0, idx1 and twiddle outputs = 0.
  - bf_op_o = AluOpPqButterflyCT.
- start_i at cycle t gives bf_valid_o = 1 with the first butterfly at t+1.
- Throughput: one butterfly per cycle while bf_ready_i is held high.
- With bf_valid_o high and bf_ready_i low, all bf_* outputs hold stable.
- Completion:
  - Last handshake at cycle t gives done_o = 1 at t+1; busy_o = 0 at t+2.
  - The earliest accepted restart is start_i at t+2.
- All outputs are registered. bf_valid_o never combinationally depends on bf_ready_i.
- Reset mid-transform returns immediately to IDLE with reset values.

## Structure
- Shared PQ package additions: ntt_seq_state_e enum {NttSeqIdle, NttSeqIssue, NttSeqDone}.
- Reuse alu_op_pq_e from the same package.
- One sub-module, otbn_pq_ntt_addr_gen: combinational next-(j, base, len, k, last) computation from the current counters and the direction. The FSM and registers stay in otbn_pq_ntt_seq.

## Test plan
- Forward, LogN=3, bf_ready_i tied high: 12 butterflies (idx0,idx1,k):
  - len=4: (0,4,1) (1,5,1) (2,6,1) (3,7,1).
  - len=2: (0,2,2) (1,3,2) (4,6,3) (5,7,3).
  - len=1: (0,1,4) (2,3,5) (4,5,6) (6,7,7).
  - bf_last_o only on the 12th; done_o one cycle later.
- Inverse, LogN=3, bf_ready_i tied high:
  - len=1: (0,1,7) (2,3,6) (4,5,5) (6,7,4).
  - len=2: (0,2,3) (1,3,3) (4,6,2) (5,7,2).
  - len=4: (0,4,1) (1,5,1) (2,6,1) (3,7,1).
  - bf_op_o = AluOpPqButterflyGS throughout.
- Random bf_ready_i stalls, LogN=8: exactly 1024 handshakes; outputs stable during every stall; sequence identical to the unstalled run.
- abort_i asserted on the 5th butterfly together with bf_ready_i: next cycle IDLE, no done_o; a new start_i then restarts at (0,N/2,1).
- start_i pulsed during ISSUE and DONE: ignored, sequence unaffected. rst_i mid-transform: all outputs return to reset values asynchronously.
